// File: rtl/t07_spitft_resp_if.sv
// SPI pin bundle between the TFT link master and the display-side responder.
interface t07_spitft_resp_if;
  logic sclk;
  logic chipSelect;
  logic bitData;
  logic miso;

  modport master (output sclk, output chipSelect, output bitData, input miso);
  modport slave  (input sclk, input chipSelect, input bitData, output miso);
endinterface

// File: rtl/t07_spitft_resp.sv
// TFT SPI responder: deserializes 16-bit frames {R/nW, addr[6:0], data[7:0]}
// into an NREGS x 8 register file. Read-back on miso is compiled in only when
// T07_SPITFT_RESP_READBACK_EN is defined; otherwise miso is tied low.
module t07_spitft_resp #(
  parameter int NREGS       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  t07_spitft_resp_if.slave spi,
  output logic             wr_strobe,
  output logic [6:0]       wr_addr,
  output logic [7:0]       wr_data,
  output logic             frame_done,
  output logic             frame_err,
  input  logic [2:0]       reg_sel,
  output logic [7:0]       reg_out
);

  localparam int         AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [7:0] NREGS_W = 8'(NREGS);

  typedef enum logic [2:0] {IDLE, CMD, DATA, DONE, HOLD} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sy, cs_sy, dat_sy;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, dat_s;
  logic                   rise, cs_fall;
  logic [4:0]             bcnt, bcnt_nx;
  // Only the low byte is ever consumed: it holds the command byte after the
  // 8th rise and the data byte after the 16th.
  logic [7:0]             sr, sr_nx;
  logic [6:0]             addr;
  logic                   rnw;
  logic                   addr_ok;
  logic                   err_done;
  logic [7:0]             regs [NREGS];

  assign sclk_s  = sclk_sy[SYNC_STAGES-1];
  assign cs_s    = cs_sy[SYNC_STAGES-1];
  assign dat_s   = dat_sy[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_d;
  assign cs_fall = cs_d & ~cs_s;
  assign bcnt_nx = bcnt + 5'd1;
  assign sr_nx   = {sr[6:0], dat_s};
  assign addr_ok = {1'b0, addr} < NREGS_W;

  // Debug read port, out-of-range selects read as zero.
  assign reg_out = ({5'b0, reg_sel} < NREGS_W) ? regs[AW'(reg_sel)] : 8'h00;

  // Synchronizers, frame FSM, register file and completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sy    <= '0;
      cs_sy      <= '1;
      dat_sy     <= '0;
      sclk_d     <= 1'b0;
      cs_d       <= 1'b1;
      state      <= IDLE;
      bcnt       <= '0;
      sr         <= '0;
      addr       <= '0;
      rnw        <= 1'b0;
      err_done   <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else begin
      sclk_sy    <= {sclk_sy[SYNC_STAGES-2:0], spi.sclk};
      cs_sy      <= {cs_sy[SYNC_STAGES-2:0], spi.chipSelect};
      dat_sy     <= {dat_sy[SYNC_STAGES-2:0], spi.bitData};
      sclk_d     <= sclk_s;
      cs_d       <= cs_s;
      wr_strobe  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: if (cs_fall) begin
          state    <= CMD;
          bcnt     <= '0;
          sr       <= '0;
          err_done <= 1'b0;
        end
        // Deassert is checked before rise so it wins a same-cycle tie.
        CMD: if (cs_s) begin
          frame_err <= 1'b1;
          state     <= IDLE;
        end else if (rise) begin
          sr   <= sr_nx;
          bcnt <= bcnt_nx;
          if (bcnt_nx == 5'd8) begin
            rnw   <= sr_nx[7];
            addr  <= sr_nx[6:0];
            state <= DATA;
          end
        end
        // Completion actions fire on the 16th rise so they land one clk later.
        DATA: if (cs_s) begin
          frame_err <= 1'b1;
          state     <= IDLE;
        end else if (rise) begin
          sr   <= sr_nx;
          bcnt <= bcnt_nx;
          if (bcnt_nx == 5'd16) begin
            state      <= DONE;
            frame_done <= 1'b1;
            wr_addr    <= addr;
            wr_data    <= sr_nx;
            if (!rnw) begin
              wr_strobe <= 1'b1;
              if (addr_ok) regs[AW'(addr)] <= sr_nx;
            end
          end
        end
        DONE: state <= HOLD;
        // Extra clocks after a full frame flag one overrun per frame.
        HOLD: if (cs_s) begin
          state <= IDLE;
        end else if (rise && !err_done) begin
          frame_err <= 1'b1;
          err_done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef T07_SPITFT_RESP_READBACK_EN
  logic       fall;
  logic       miso_q;
  logic       loaded;
  logic [7:0] miso_sr;
  logic [7:0] rd_byte;

  assign fall    = ~sclk_s & sclk_d;
  assign rd_byte = addr_ok ? regs[AW'(addr)] : 8'h00;
  assign spi.miso = miso_q & ~cs_s & (state != IDLE);

  // Read shifter: first fall in DATA loads the byte, later falls shift it out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_q  <= 1'b0;
      loaded  <= 1'b0;
      miso_sr <= '0;
    end else if (state == IDLE || cs_s) begin
      miso_q <= 1'b0;
      loaded <= 1'b0;
    end else if (state == DATA && fall && rnw) begin
      if (!loaded) begin
        miso_q  <= rd_byte[7];
        miso_sr <= {rd_byte[6:0], 1'b0};
        loaded  <= 1'b1;
      end else begin
        miso_q  <= miso_sr[7];
        miso_sr <= {miso_sr[6:0], 1'b0};
      end
    end
  end
`else
  assign spi.miso = 1'b0;
`endif

endmodule

// File: tb/tb_t07_spitft_resp.sv
// Directed bench for t07_spitft_resp: write/read frames, out-of-range address,
// aborted frame, overrun frame and mid-frame reset.
module tb_t07_spitft_resp;
  logic       clk = 1'b0;
  logic       rst;
  logic       wr_strobe, frame_done, frame_err;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] reg_sel;
  logic [7:0] reg_out;

  t07_spitft_resp_if spi ();

  t07_spitft_resp dut (
    .clk        (clk),
    .rst        (rst),
    .spi        (spi.slave),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .reg_sel    (reg_sel),
    .reg_out    (reg_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_wr = 0, n_done = 0, n_err = 0, n_miso = 0;
  int b_wr, b_done, b_err;
  logic [7:0] exp_regs [8];
  logic [7:0] rd;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_strobe)  n_wr++;
    if (frame_done) n_done++;
    if (frame_err)  n_err++;
    if (spi.miso)   n_miso++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_wr = n_wr; b_done = n_done; b_err = n_err;
  endtask

  task automatic chk_pulses(input string tag, input int wr, input int done, input int err);
    chk({tag, ".wr_strobe"},  n_wr - b_wr, wr);
    chk({tag, ".frame_done"}, n_done - b_done, done);
    chk({tag, ".frame_err"},  n_err - b_err, err);
  endtask

  task automatic chk_regs(input string tag);
    for (int s = 0; s < 8; s++) begin
      reg_sel = 3'(s);
      #1;
      chk($sformatf("%s.reg%0d", tag, s), reg_out, exp_regs[s]);
    end
  endtask

  // One frame at sclk = clk/10; nbits > 16 sends overrun clocks with zero data.
  // rst_bit >= 0 asserts rst just before that bit's rising edge and stops.
  task automatic send(input logic [15:0] f, input int nbits, input int rst_bit,
                      output logic [7:0] rdb);
    rdb = 8'h00;
    spi.chipSelect = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi.bitData = (i < 16) ? f[15-i] : 1'b0;
      repeat (5) @(negedge clk);
      if (i == rst_bit) begin
        rst = 1'b1;
        break;
      end
      if (i >= 8 && i < 16) rdb[15-i] = spi.miso;
      spi.sclk = 1'b1;
      repeat (5) @(negedge clk);
      spi.sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
    spi.chipSelect = 1'b1;
    spi.bitData    = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    spi.sclk = 1'b0; spi.chipSelect = 1'b1; spi.bitData = 1'b0;
    reg_sel = 3'd0;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst.wr_addr", wr_addr, 0);
    chk("rst.wr_data", wr_data, 0);
    chk("rst.miso", spi.miso, 0);
    chk("rst.pulses", {wr_strobe, frame_done, frame_err}, 0);
    chk_regs("rst");

    snap(); send(16'h051D, 16, -1, rd); exp_regs[5] = 8'h1D;
    chk_pulses("w051D", 1, 1, 0);
    chk("w051D.wr_addr", wr_addr, 8'h05);
    chk("w051D.wr_data", wr_data, 8'h1D);
    chk_regs("w051D");

    snap(); send(16'h8500, 16, -1, rd);
`ifdef T07_SPITFT_RESP_READBACK_EN
    chk("r8500.miso", rd, 8'h1D);
`else
    chk("r8500.miso", rd, 8'h00);
`endif
    chk_pulses("r8500", 0, 1, 0);
    chk("r8500.wr_addr", wr_addr, 8'h05);

    snap(); send(16'h0A55, 16, -1, rd);
    chk_pulses("w0A55", 1, 1, 0);
    chk("w0A55.wr_addr", wr_addr, 8'h0A);
    chk("w0A55.wr_data", wr_data, 8'h55);
    chk_regs("w0A55");

    snap(); send(16'h8A00, 16, -1, rd);
    chk("r8A00.miso", rd, 8'h00);
    chk_pulses("r8A00", 0, 1, 0);
    chk("r8A00.wr_addr", wr_addr, 8'h0A);

    snap(); send(16'h0377, 10, -1, rd);
    chk_pulses("abort", 0, 0, 1);
    chk("abort.wr_addr", wr_addr, 8'h0A);
    chk("abort.wr_data", wr_data, 8'h00);
    chk_regs("abort");

    snap(); send(16'h0142, 18, -1, rd); exp_regs[1] = 8'h42;
    chk_pulses("ovr", 1, 1, 1);
    chk("ovr.wr_data", wr_data, 8'h42);
    chk_regs("ovr");

    snap(); send(16'h04AA, 16, 11, rd);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    chk_pulses("midrst", 0, 0, 0);
    chk("midrst.wr_addr", wr_addr, 0);
    chk_regs("midrst");

    snap(); send(16'h0201, 16, -1, rd); exp_regs[2] = 8'h01;
    chk_pulses("w0201", 1, 1, 0);
    chk("w0201.wr_addr", wr_addr, 8'h02);
    chk_regs("w0201");

    snap(); send(16'h8200, 16, -1, rd);
`ifdef T07_SPITFT_RESP_READBACK_EN
    chk("r8200.miso", rd, 8'h01);
`else
    chk("r8200.miso", rd, 8'h00);
    chk("miso_never_high", n_miso, 0);
`endif
    chk_pulses("r8200", 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/t07_spitft_resp.md
# t07_spitft_resp

SPI responder that models the display-controller end of the team's TFT SPI link. It deserializes 16-bit command frames driven by the SPI master (`sclk`, `chipSelect`, `bitData`) into an internal 8 x 8-bit register file. For read frames it shifts register contents back on `miso`. It sits on the display side of the link as a synthesizable loopback/bring-up target, and doubles as the bench model for master-side tests.

## Interface
- `NREGS`, 8: register-file depth; valid addresses are 0..NREGS-1 and NREGS ≤ 128.
- `SYNC_STAGES`, 2: synchronizer depth on `sclk`, `chipSelect` and `bitData`; minimum 2.
- `clk` in 1: system clock; must be ≥ 4x the `sclk` frequency.
- `rst` in 1: asynchronous, active-high reset.
- `sclk` in 1: SPI clock from the master, mode 0 (idle low).
- `chipSelect` in 1: active-low frame enable.
- `bitData` in 1: MOSI, MSB first.
- `miso` out 1: read data to the master.
- `wr_strobe` out 1: one-cycle pulse when a write frame completes.
- `wr_addr` out 7: address of the last completed frame.
- `wr_data` out 8: data byte of the last completed frame.
- `frame_done` out 1: one-cycle pulse on any complete 16-bit frame.
- `frame_err` out 1: one-cycle pulse on an aborted or overrun frame.
- `reg_sel` in 3 and `reg_out` out 8: combinational debug read port; `reg_out` = `regs[reg_sel]`.

## Operation
- Frame format: bit15 = R/nW (1 = read); bits14:8 = address; bits7:0 = write data (ignored on reads).
- Inputs pass through `SYNC_STAGES` flops. Edge detect on synchronized `sclk` gives `rise` and `fall`. `chipSelect` falling marks frame start.
- States:
  - IDLE: `chipSelect` low → CMD; clear bit counter `bcnt` (5 bits) and shift register `sr`.
  - CMD: on `rise`, `sr <= {sr[14:0], bitData}` and `bcnt++`. When `bcnt` reaches 8, latch address and R/nW, then go to DATA.
  - DATA: on `rise`, keep shifting. On the `rise` where `bcnt` reaches 16, go to DONE.
  - DONE: pulse `frame_done` and assert outputs (see below), then go to HOLD.
  - HOLD: ignore `sclk` until `chipSelect` rises, then go to IDLE.
- DONE actions:
  - `wr_addr` and `wr_data` update on every complete frame.
  - Write frame with address < NREGS: `regs[addr] <= sr[7:0]` and `wr_strobe` = 1 for one cycle.
  - Write frame with address ≥ NREGS: `wr_strobe` still pulses; no register changes.
- Read path:
  - On the first `fall` after the 8th `rise`, load the miso shift register with `regs[addr]` (0x00 if address ≥ NREGS) and drive bit7.
  - Each later `fall` in DATA shifts out the next bit.
- Boundary conditions:
  - `chipSelect` rises in CMD or DATA: pulse `frame_err`, no `frame_done`, no write, go to IDLE.
  - Any `rise` in HOLD (17th+ bit): pulse `frame_err` once per frame; the completed write stands.
  - `rise` and `chipSelect` deassert detected in the same cycle: the deassert wins.
  - `rst` mid-frame aborts the frame silently; no `frame_err` is raised.

## Timing
- Reset values: `miso` 0, `wr_strobe` 0, `wr_addr` 0, `wr_data` 0, `frame_done` 0, `frame_err` 0, all `regs` 0x00, state IDLE.
- Input-to-detect latency: `SYNC_STAGES`+1 `clk` cycles from a pin edge.
- `frame_done`, `wr_strobe` and the register write occur 1 `clk` after the 16th `rise` detect.
- `miso` changes 1 `clk` after a `fall` detect, so it is stable well before the next master sampling edge at ≥ 4x oversampling.
- `miso` is forced to 0 whenever synchronized `chipSelect` is high or the state is IDLE.
- A register written by frame N is visible to a read in frame N+1 with no gap.

## Configuration
- `T07_SPITFT_RESP_READBACK_EN` defined: the read path operates as described.
- Not defined:
  - `miso` is tied to 0 and the miso shifter logic is removed.
  - Read frames still complete: `frame_done` pulses and `wr_addr` updates.
  - Read frames never write registers and never raise `wr_strobe`.

## Test plan
- Write frame 16'h051D at `sclk` = `clk`/10 → one `wr_strobe` pulse, `wr_addr` = 0x05, `wr_data` = 0x1D, `reg_out` = 0x1D with `reg_sel` = 5.
- Then read frame 16'h8500 → `miso` bits 8..15 = 0,0,0,1,1,1,0,1; `frame_done` pulses, no `wr_strobe`.
- Write 16'h0A55 (address 10) → `wr_strobe` pulses, all regs unchanged; read 16'h8A00 returns 0x00.
- Raise `chipSelect` after 10 bits of 16'h0377 → `frame_err` pulses, reg3 unchanged, no `frame_done`.
- 18 `sclk` pulses on 16'h0142 → reg1 = 0x42, one `frame_done`, one `frame_err`.
- Assert `rst` during bit 12 of a write, release, then send 16'h0201 → no pulses from the first frame; the second frame writes reg2 = 0x01; with the macro undefined, `miso` stays 0 on reads.
